mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address bits; RAM is 2^ADDR_WIDTH x 32-bit words at byte addresses 0 to 4*2^ADDR_WIDTH-1.
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before each access (0..15).
REQ-003 SHALL have parameter INIT_FILE, default "" (none), hex image preloaded into RAM at elaboration.
REQ-004 mclk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mem_address  input  32  byte address from initiator.
REQ-007 mem_rw_req  input  1  level request; held high until mem_rec is seen.
REQ-008 mem_rw  input  1  0 = read, 1 = write.
REQ-009 mem_write_data  input  32  store data, right-justified.
REQ-010 mem_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-011 mem_read_data  output  32  load data, right-justified, zero-filled above size.
REQ-012 mem_rec  output  1  one-cycle completion strobe.
REQ-013 bus_err  output  1  sticky error flag.
REQ-014 err_addr  output  32  address of first faulting access.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-016 IDLE: mem_rw_req high at a rising edge SHALL latch address, rw, size and write data, then go to WAIT (or to ACCESS if WAIT_STATES=0).
REQ-017 WAIT SHALL last exactly WAIT_STATES cycles (down-counter), then go to ACCESS.
REQ-018 ACCESS SHALL perform one synchronous RAM read or byte-enabled write, then go to RESP.
REQ-019 RESP SHALL drive mem_rec=1 for exactly one cycle, then go to IDLE unconditionally, without accepting a request on that edge.
REQ-020 SHALL produce mem_rec high in the cycle beginning WAIT_STATES+2 edges after the accepting edge.
REQ-021 Back-to-back requests (req held high, address changed on the mem_rec edge) SHALL be accepted on the first IDLE edge, giving one request per WAIT_STATES+3 cycles and no duplicate accept of the old address.
REQ-022 mem_rw_req deasserting after acceptance SHALL NOT abort; the latched transaction SHALL complete and pulse mem_rec.
REQ-023 Little-endian byte lanes: byte uses lane addr[1:0]; half uses lanes {addr[1],0}..{addr[1],1}; word uses all four lanes.
REQ-024 Byte/half write SHALL write only mem_write_data[7:0] / [15:0] into the selected lanes; other lanes are unchanged.
REQ-025 Reads SHALL shift the selected lanes to bit 0 and zero bits above size; sign extension is the initiator's job.
REQ-026 mem_read_data SHALL be updated only in RESP of a read; it holds its value through writes and idle cycles.
REQ-027 Faults: address >= 4*2^ADDR_WIDTH, half with addr[0]=1, word with addr[1:0]!=0, or mem_size=3.
REQ-028 On a fault, writes SHALL leave RAM unchanged and reads SHALL return 0; mem_rec SHALL still pulse with normal latency.
REQ-029 On the first fault since reset, bus_err SHALL set and err_addr SHALL capture the address; later faults SHALL NOT change err_addr.

Reset
REQ-030 reset low SHALL immediately force state IDLE, mem_rec=0, mem_read_data=0, bus_err=0, err_addr=0 and the wait counter to 0.
REQ-031 Reset SHALL NOT clear RAM contents; a transaction in flight is dropped with no write and no mem_rec.
REQ-032 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 Word write 0xDEADBEEF to 0x18, then word read 0x18 with WAIT_STATES=1 -> mem_rec on the 3rd edge after accept; read data 0xDEADBEEF.
REQ-034 Byte write 0x5A to 0x101 over 0x11223344 at 0x100 -> word read gives 0x11225A44; byte read 0x103 gives 0x00000011; half read 0x102 gives 0x00001122.
REQ-035 Burst of 8 word reads 0x20..0x3C with req held high and address stepped on each mem_rec -> exactly 8 mem_rec pulses, correct data in order, no repeated address.
REQ-036 Word read at 0x00000006, then write to 0x00010000 (ADDR_WIDTH=12) -> mem_rec pulses for both; read data 0; bus_err=1; err_addr=0x00000006; RAM unchanged.
REQ-037 Assert reset during WAIT of a write to 0x40 -> no mem_rec, 0x40 retains its old value, outputs 0; after release a read of 0x40 completes normally.
REQ-038 Request with mem_rw_req dropped one cycle after accept -> mem_rec still pulses once; the next request is accepted normally.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_responder: word-organised RAM slave with programmable wait states,
// little-endian byte lanes and sticky fault capture.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [31:0] mem_address,
    input  logic        mem_rw_req,
    input  logic        mem_rw,
    input  logic [31:0] mem_write_data,
    input  logic [1:0]  mem_size,
    output logic [31:0] mem_read_data,
    output logic        mem_rec,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int       c_DEPTH     = 1 << ADDR_WIDTH;
    localparam bit [3:0] c_WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_rec_q, mem_rec_d;
    logic [31:0] read_data_q, read_data_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0] ram [c_DEPTH];
    logic [31:0] ram_rdata_q;

    logic                  w_fault;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic [3:0]            w_be;
    logic [31:0]           w_wlane;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_shifted;
    logic [31:0]           w_fmt;

    assign w_idx = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        w_out_of_range = (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
        case (size_q)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = addr_q[0];
            2'd2:    w_misaligned = addr_q[1:0] != 2'b00;
            default: w_misaligned = 1'b1;
        endcase
        w_fault = w_out_of_range || w_misaligned;
    end

    // Narrow stores replicate their data across lanes; the enables pick the lane.
    always_comb begin
        case (size_q)
            2'd0: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_wlane = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = wdata_q;
            end
        endcase
        w_ram_we = (state_q == S_ACCESS) && rw_q && !w_fault;
    end

    always_comb begin
        w_shifted = ram_rdata_q >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    w_fmt = {24'd0, w_shifted[7:0]};
            2'd1:    w_fmt = {16'd0, w_shifted[15:0]};
            default: w_fmt = w_shifted;
        endcase
        if (w_fault) begin
            w_fmt = 32'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        mem_rec_d   = 1'b0;
        read_data_d = read_data_q;
        bus_err_d   = bus_err_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (mem_rw_req) begin
                    addr_d  = mem_address;
                    rw_d    = mem_rw;
                    size_d  = mem_size;
                    wdata_d = mem_write_data;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = c_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (w_fault && !bus_err_q) begin
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                end
            end
            default: begin
                // Completion strobe and load data become visible together next cycle.
                mem_rec_d = 1'b1;
                if (!rw_q) begin
                    read_data_d = w_fmt;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 32'd0;
            rw_q        <= 1'b0;
            size_q      <= 2'd0;
            wdata_q     <= 32'd0;
            mem_rec_q   <= 1'b0;
            read_data_q <= 32'd0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            mem_rec_q   <= mem_rec_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge mclk) begin
        if (state_q == S_ACCESS) begin
            ram_rdata_q <= ram[w_idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we && w_be[i]) begin
                ram[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    assign mem_read_data = read_data_q;
    assign mem_rec       = mem_rec_q;
    assign bus_err       = bus_err_q;
    assign err_addr      = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_responder: directed bench for mem_responder (ADDR_WIDTH=12, WAIT_STATES=1).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_responder;

    logic        mclk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_address = 32'd0;
    logic        mem_rw_req = 1'b0;
    logic        mem_rw = 1'b0;
    logic [31:0] mem_write_data = 32'd0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_read_data;
    logic        mem_rec;
    logic        bus_err;
    logic [31:0] err_addr;

    int vectors = 0;
    int miscompares = 0;

    mem_responder #(
        .ADDR_WIDTH (12),
        .WAIT_STATES(1),
        .INIT_FILE  ("")
    ) dut (
        .mclk          (mclk),
        .reset         (reset),
        .mem_address   (mem_address),
        .mem_rw_req    (mem_rw_req),
        .mem_rw        (mem_rw),
        .mem_write_data(mem_write_data),
        .mem_size      (mem_size),
        .mem_read_data (mem_read_data),
        .mem_rec       (mem_rec),
        .bus_err       (bus_err),
        .err_addr      (err_addr)
    );

    always #5 mclk = ~mclk;

    // One transaction: lat = edges after the accepting edge until mem_rec is seen, -1 on timeout.
    task automatic txn(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic got;
        @(posedge mclk); #1;
        mem_rw_req = 1'b1; mem_rw = rw; mem_address = a; mem_size = sz; mem_write_data = wd;
        @(posedge mclk);
        got = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge mclk); #1;
            if (mem_rec) begin
                got = 1'b1;
                lat = i;
            end
        end
        rd = mem_read_data;
        mem_rw_req = 1'b0;
    endtask

    task automatic test_reset;
        int lat;
        logic got;
        mem_rw_req = 1'b0;
        #20;
        vectors++; if (mem_rec !== 1'b0) begin miscompares++; $display("FAIL reset_rec: got %b expected 0", mem_rec); end
        vectors++; if (mem_read_data !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", mem_read_data); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_buserr: got %b expected 0", bus_err); end
        vectors++; if (err_addr !== 32'd0) begin miscompares++; $display("FAIL reset_erraddr: got %h expected 00000000", err_addr); end
        // Request already pending when reset lifts must be taken on the very next edge.
        mem_rw_req = 1'b1; mem_rw = 1'b1; mem_address = 32'h0; mem_size = 2'd2; mem_write_data = 32'hCAFEF00D;
        #3 reset = 1'b1;
        @(posedge mclk);
        got = 1'b0; lat = -1;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge mclk); #1;
            if (mem_rec) begin got = 1'b1; lat = i; end
        end
        mem_rw_req = 1'b0;
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL first_accept_lat: got %0d expected 3", lat); end
    endtask

    task automatic test_word_rw;
        logic [31:0] rd;
        int lat;
        txn(1'b1, 32'h18, 2'd2, 32'hDEADBEEF, rd, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL word_wr_lat: got %0d expected 3", lat); end
        txn(1'b0, 32'h18, 2'd2, 32'h0, rd, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL word_rd_lat: got %0d expected 3", lat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_rd_data: got %h expected deadbeef", rd); end
        @(posedge mclk); #1;
        vectors++; if (mem_rec !== 1'b0) begin miscompares++; $display("FAIL rec_one_cycle: got %b expected 0", mem_rec); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd;
        int lat;
        txn(1'b1, 32'h100, 2'd2, 32'h11223344, rd, lat);
        vectors++; if (mem_read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rdata_hold_wr: got %h expected deadbeef", mem_read_data); end
        txn(1'b1, 32'h101, 2'd0, 32'h0000005A, rd, lat);
        txn(1'b0, 32'h100, 2'd2, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h11225A44) begin miscompares++; $display("FAIL byte_wr_word: got %h expected 11225a44", rd); end
        txn(1'b0, 32'h103, 2'd0, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h00000011) begin miscompares++; $display("FAIL byte_rd_103: got %h expected 00000011", rd); end
        txn(1'b0, 32'h102, 2'd1, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h00001122) begin miscompares++; $display("FAIL half_rd_102: got %h expected 00001122", rd); end
        txn(1'b1, 32'h102, 2'd1, 32'hFFFFBEEF, rd, lat);
        txn(1'b0, 32'h100, 2'd2, 32'h0, rd, lat);
        vectors++; if (rd !== 32'hBEEF5A44) begin miscompares++; $display("FAIL half_wr_word: got %h expected beef5a44", rd); end
        txn(1'b1, 32'h102, 2'd0, 32'hFFFFFF77, rd, lat);
        txn(1'b0, 32'h100, 2'd2, 32'h0, rd, lat);
        vectors++; if (rd !== 32'hBE775A44) begin miscompares++; $display("FAIL byte_wr_102: got %h expected be775a44", rd); end
        txn(1'b0, 32'h100, 2'd0, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h00000044) begin miscompares++; $display("FAIL byte_rd_100: got %h expected 00000044", rd); end
        txn(1'b0, 32'h100, 2'd1, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h00005A44) begin miscompares++; $display("FAIL half_rd_100: got %h expected 00005a44", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int lat;
        int n;
        int last;
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 32'h20 + 32'(4*i), 2'd2, 32'hA5000020 + 32'(4*i), rd, lat);
        end
        @(posedge mclk); #1;
        mem_rw_req = 1'b1; mem_rw = 1'b0; mem_size = 2'd2; mem_address = 32'h20;
        n = 0; last = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge mclk); #1;
            if (mem_rec) begin
                vectors++;
                if (mem_read_data !== 32'hA5000020 + 32'(4*n)) begin
                    miscompares++;
                    $display("FAIL burst_data[%0d]: got %h expected %h", n, mem_read_data, 32'hA5000020 + 32'(4*n));
                end
                if (n > 0) begin
                    vectors++;
                    if (c - last !== 4) begin miscompares++; $display("FAIL burst_spacing[%0d]: got %0d expected 4", n, c - last); end
                end
                last = c;
                n++;
                if (n >= 8) mem_rw_req = 1'b0;
                else mem_address = 32'h20 + 32'(4*n);
            end
        end
        mem_rw_req = 1'b0;
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL burst_count: got %0d expected 8", n); end
    endtask

    task automatic test_faults;
        logic [31:0] rd;
        int lat;
        txn(1'b0, 32'h6, 2'd2, 32'h0, rd, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL fault_rd_lat: got %0d expected 3", lat); end
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL fault_rd_data: got %h expected 00000000", rd); end
        vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL fault_buserr: got %b expected 1", bus_err); end
        vectors++; if (err_addr !== 32'h6) begin miscompares++; $display("FAIL fault_erraddr: got %h expected 00000006", err_addr); end
        txn(1'b1, 32'h00010000, 2'd2, 32'h12345678, rd, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL fault_wr_lat: got %0d expected 3", lat); end
        vectors++; if (err_addr !== 32'h6) begin miscompares++; $display("FAIL erraddr_sticky: got %h expected 00000006", err_addr); end
        txn(1'b1, 32'h101, 2'd1, 32'h0000FFFF, rd, lat);
        txn(1'b0, 32'h100, 2'd3, 32'h0, rd, lat);
        vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL size3_rd: got %h expected 00000000", rd); end
        txn(1'b0, 32'h0, 2'd2, 32'h0, rd, lat);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL oor_no_alias: got %h expected cafef00d", rd); end
        txn(1'b0, 32'h100, 2'd2, 32'h0, rd, lat);
        vectors++; if (rd !== 32'hBE775A44) begin miscompares++; $display("FAIL misaligned_no_wr: got %h expected be775a44", rd); end
        vectors++; if (err_addr !== 32'h6) begin miscompares++; $display("FAIL erraddr_final: got %h expected 00000006", err_addr); end
    endtask

    task automatic test_reset_in_flight;
        logic [31:0] rd;
        int lat;
        int pulses;
        txn(1'b1, 32'h40, 2'd2, 32'h01010101, rd, lat);
        @(posedge mclk); #1;
        mem_rw_req = 1'b1; mem_rw = 1'b1; mem_address = 32'h40; mem_size = 2'd2; mem_write_data = 32'hFFFFFFFF;
        @(posedge mclk); #1;
        reset = 1'b0;
        #1;
        vectors++; if (mem_read_data !== 32'd0) begin miscompares++; $display("FAIL rst_fl_rdata: got %h expected 00000000", mem_read_data); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL rst_fl_buserr: got %b expected 0", bus_err); end
        vectors++; if (err_addr !== 32'd0) begin miscompares++; $display("FAIL rst_fl_erraddr: got %h expected 00000000", err_addr); end
        mem_rw_req = 1'b0;
        @(posedge mclk); @(posedge mclk); #1;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge mclk); #1;
            if (mem_rec) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rst_fl_norec: got %0d expected 0", pulses); end
        txn(1'b0, 32'h40, 2'd2, 32'h0, rd, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rst_fl_rd_lat: got %0d expected 3", lat); end
        vectors++; if (rd !== 32'h01010101) begin miscompares++; $display("FAIL rst_fl_kept: got %h expected 01010101", rd); end
    endtask

    task automatic test_req_drop;
        logic [31:0] rd;
        int lat;
        int pulses;
        int first;
        @(posedge mclk); #1;
        mem_rw_req = 1'b1; mem_rw = 1'b0; mem_address = 32'h18; mem_size = 2'd2;
        @(posedge mclk);
        pulses = 0; first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge mclk); #1;
            if (i == 1) mem_rw_req = 1'b0;
            if (mem_rec) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL drop_pulses: got %0d expected 1", pulses); end
        vectors++; if (first !== 3) begin miscompares++; $display("FAIL drop_lat: got %0d expected 3", first); end
        vectors++; if (mem_read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL drop_data: got %h expected deadbeef", mem_read_data); end
        txn(1'b0, 32'h100, 2'd2, 32'h0, rd, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL after_drop_lat: got %0d expected 3", lat); end
        vectors++; if (rd !== 32'hBE775A44) begin miscompares++; $display("FAIL after_drop_data: got %h expected be775a44", rd); end
    endtask

    initial begin
        test_reset;
        test_word_rw;
        test_byte_lanes;
        test_back_to_back;
        test_faults;
        test_reset_in_flight;
        test_req_drop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
